sgf_mult_round_norm: RTL and testbench

// - Downstream stage of the significand multiplier: consumes the registered 2*SW-bit product.
// - Normalizes the product by a 0/1-bit shift and rounds it to MW bits (IEEE-754 modes).
// - Reports exponent-adjust flags to the exponent path.
// - Multi-cycle FSM with a valid/ready output handshake.

---
 rtl/sgf_round_defs.sv | 18 +
 rtl/sgf_norm_extract.sv | 29 ++
 rtl/sgf_mult_round_norm.sv | 142 ++++++++++++++
 tb/tb_sgf_mult_round_norm.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sgf_round_defs.sv
// Shared definitions for the significand round/normalize path: rounding modes and FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sgf_round_defs;

  localparam logic [1:0] RM_RNE = 2'b00;  // round to nearest, ties to even
  localparam logic [1:0] RM_RTZ = 2'b01;  // round toward zero
  localparam logic [1:0] RM_RUP = 2'b10;  // round toward +inf
  localparam logic [1:0] RM_RDN = 2'b11;  // round toward -inf

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_NORM  = 2'b01,
    ST_ROUND = 2'b10,
    ST_HOLD  = 2'b11
  } rnd_state_t;

endpackage

// File: rtl/sgf_norm_extract.sv
// Splits a 2*MW-bit product into kept significand, guard, sticky and normalization flags.
// Latency: combinational.
// Backpressure: none; pure function of the product.
module sgf_norm_extract #(
  parameter int MW = 53
) (
  input  logic [2*MW-1:0] prod,
  output logic [MW-1:0]   m,
  output logic            g,
  output logic            s,
  output logic            norm_inc,
  output logic            err
);

  // Top product bit decides between the 1-bit-shifted and unshifted windows.
  always_comb begin
    norm_inc = prod[2*MW-1];
    err      = ~prod[2*MW-1] & ~prod[2*MW-2];
    m        = prod[2*MW-2:MW-1];
    g        = prod[MW-2];
    s        = |prod[MW-3:0];
    if (prod[2*MW-1]) begin
      m = prod[2*MW-1:MW];
      g = prod[MW-1];
      s = |prod[MW-2:0];
    end
  end

endmodule

// File: rtl/sgf_mult_round_norm.sv
// Normalizes a registered significand product and rounds it to MW bits in any IEEE-754 mode.
// Latency: start edge k -> valid_o high after edge k+2; one result per 3 cycles at best.
// Backpressure: result held in HOLD until valid_o & ready_i; start_i ignored while busy otherwise.
module sgf_mult_round_norm
  import sgf_round_defs::*;
#(
  parameter int SW = 54,
  parameter int MW = 53
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2*SW-1:0] sgf_prod_i,
  input  logic [1:0]      rmode_i,
  input  logic            sign_i,
  input  logic            ready_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [MW-1:0]   sgf_o,
  output logic            norm_inc_o,
  output logic            rnd_ovf_o,
  output logic            inexact_o,
  output logic            err_o
);

  rnd_state_t state_q, state_d;

  logic [2*MW-1:0] prod_q;
  logic [1:0]      rmode_q;
  logic            sign_q;
  logic [MW-1:0]   m_q;
  logic            g_q, s_q, ninc_q, err_q;

  logic [MW-1:0]   m_c;
  logic            g_c, s_c, ninc_c, err_c;
  logic            inc;
  logic [MW:0]     sum;
  logic            xfer, capture;

  // Product bits above 2*MW never reach the datapath.
  if (SW > MW) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^sgf_prod_i[2*SW-1:2*MW];
  end

  assign xfer    = (state_q == ST_HOLD) & ready_i;
  assign capture = start_i & ((state_q == ST_IDLE) | xfer);

  sgf_norm_extract #(.MW(MW)) u_extract (
    .prod     (prod_q),
    .m        (m_c),
    .g        (g_c),
    .s        (s_c),
    .norm_inc (ninc_c),
    .err      (err_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: fixed NORM/ROUND walk, HOLD leaves only on transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_NORM;
      ST_NORM:  state_d = ST_ROUND;
      ST_ROUND: state_d = ST_HOLD;
      ST_HOLD:  if (ready_i) state_d = start_i ? ST_NORM : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state only.
  always_comb begin
    busy_o  = (state_q != ST_IDLE);
    valid_o = (state_q == ST_HOLD);
  end

  // Capture product and rounding context when a new operation is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q  <= '0;
      rmode_q <= '0;
      sign_q  <= 1'b0;
    end else if (capture) begin
      prod_q  <= sgf_prod_i[2*MW-1:0];
      rmode_q <= rmode_i;
      sign_q  <= sign_i;
    end
  end

  // Register the normalized significand, guard/sticky and flags in NORM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q    <= '0;
      g_q    <= 1'b0;
      s_q    <= 1'b0;
      ninc_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (state_q == ST_NORM) begin
      m_q    <= m_c;
      g_q    <= g_c;
      s_q    <= s_c;
      ninc_q <= ninc_c;
      err_q  <= err_c;
    end
  end

  // Round-increment decision from mode, sign, guard, sticky and LSB.
  always_comb begin
    inc = 1'b0;
    case (rmode_q)
      RM_RNE:  inc = g_q & (s_q | m_q[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign_q & (g_q | s_q);
      RM_RDN:  inc = sign_q & (g_q | s_q);
      default: inc = 1'b0;
    endcase
    sum = {1'b0, m_q} + {{MW{1'b0}}, inc};
  end

  // Result registers load in ROUND and otherwise hold, including after return to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sgf_o      <= '0;
      norm_inc_o <= 1'b0;
      rnd_ovf_o  <= 1'b0;
      inexact_o  <= 1'b0;
      err_o      <= 1'b0;
    end else if (state_q == ST_ROUND) begin
      sgf_o      <= sum[MW] ? {1'b1, {(MW-1){1'b0}}} : sum[MW-1:0];
      norm_inc_o <= ninc_q;
      rnd_ovf_o  <= sum[MW];
      inexact_o  <= g_q | s_q;
      err_o      <= err_q;
    end
  end

endmodule

// File: tb/tb_sgf_mult_round_norm.sv
// Directed bench for sgf_mult_round_norm at SW=MW=8 (16-bit product).
// Inputs driven 1ns after the rising edge, outputs sampled there too.
// Expected values are hand-computed constants.
module tb_sgf_mult_round_norm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] sgf_prod_i = '0;
  logic [1:0]  rmode_i = '0;
  logic        sign_i = 1'b0;
  logic        ready_i = 1'b0;
  logic        busy_o, valid_o;
  logic [7:0]  sgf_o;
  logic        norm_inc_o, rnd_ovf_o, inexact_o, err_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sgf_mult_round_norm #(.SW(8), .MW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .sgf_prod_i (sgf_prod_i),
    .rmode_i    (rmode_i),
    .sign_i     (sign_i),
    .ready_i    (ready_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .sgf_o      (sgf_o),
    .norm_inc_o (norm_inc_o),
    .rnd_ovf_o  (rnd_ovf_o),
    .inexact_o  (inexact_o),
    .err_o      (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one product and wait (bounded) for valid_o; returns edges counted after the start edge.
  task automatic launch(input logic [15:0] p, input logic [1:0] rm, input logic sg, output int lat);
    sgf_prod_i = p;
    rmode_i    = rm;
    sign_i     = sg;
    start_i    = 1'b1;
    tick();
    start_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 8) begin
      tick();
      lat++;
    end
  endtask

  typedef struct {
    logic [15:0] prod;
    logic [1:0]  rm;
    logic        sg;
    logic [7:0]  sgf;
    logic        ninc;
    logic        ovf;
    logic        inex;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat;
    vecs[0]  = '{16'h4000, 2'b00, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'hFE01, 2'b00, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{16'hFE01, 2'b10, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{16'hFE01, 2'b10, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{16'hFE01, 2'b11, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{16'hFE01, 2'b11, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{16'h7FF9, 2'b00, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{16'h7FF9, 2'b01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{16'h4140, 2'b00, 1'b0, 8'h82, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{16'h41C0, 2'b00, 1'b0, 8'h84, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{16'h1000, 2'b00, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{16'hFFFF, 2'b10, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state.
    tick();
    tick();
    chk("rst_busy",  busy_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_sgf",   sgf_o, 0);
    chk("rst_flags", {norm_inc_o, rnd_ovf_o, inexact_o, err_o}, 0);
    rst = 1'b1;
    tick();

    // Directed rounding vectors.
    foreach (vecs[i]) begin
      launch(vecs[i].prod, vecs[i].rm, vecs[i].sg, lat);
      chk($sformatf("v%0d_lat", i), lat, 2);
      chk($sformatf("v%0d_sgf", i), sgf_o, vecs[i].sgf);
      chk($sformatf("v%0d_ninc", i), norm_inc_o, vecs[i].ninc);
      chk($sformatf("v%0d_ovf", i), rnd_ovf_o, vecs[i].ovf);
      chk($sformatf("v%0d_inex", i), inexact_o, vecs[i].inex);
      chk($sformatf("v%0d_err", i), err_o, vecs[i].err);
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      chk($sformatf("v%0d_drop", i), {busy_o, valid_o}, 0);
      chk($sformatf("v%0d_keep", i), sgf_o, vecs[i].sgf);
    end

    // Backpressure: result held stable while ready_i stays low.
    launch(16'hFE01, 2'b00, 1'b0, lat);
    chk("hold_lat", lat, 2);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("hold%0d_valid", c), valid_o, 1);
      chk($sformatf("hold%0d_sgf", c), sgf_o, 8'hFE);
    end

    // Back-to-back: new start on the transfer edge.
    sgf_prod_i = 16'h4000;
    rmode_i    = 2'b00;
    start_i    = 1'b1;
    ready_i    = 1'b1;
    tick();
    start_i = 1'b0;
    ready_i = 1'b0;
    chk("b2b_busy",  busy_o, 1);
    chk("b2b_valid0", valid_o, 0);
    tick();
    chk("b2b_valid1", valid_o, 0);
    tick();
    chk("b2b_valid2", valid_o, 1);
    chk("b2b_sgf", sgf_o, 8'h80);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("b2b_idle", busy_o, 0);

    // Start pulse during NORM is ignored: exactly one result.
    sgf_prod_i = 16'h4140;
    start_i    = 1'b1;
    tick();
    sgf_prod_i = 16'hFE01;
    tick();
    start_i = 1'b0;
    tick();
    chk("ign_valid", valid_o, 1);
    chk("ign_sgf", sgf_o, 8'h82);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("ign_quiet%0d", c), {busy_o, valid_o}, 0);
    end

    // Reset asserted in ROUND: outputs clear without a clock edge.
    sgf_prod_i = 16'hFE01;
    rmode_i    = 2'b10;
    start_i    = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    chk("rr_busy_pre", busy_o, 1);
    chk("rr_sgf_pre", sgf_o, 8'h82);
    rst = 1'b0;
    #1;
    chk("rr_busy",  busy_o, 0);
    chk("rr_valid", valid_o, 0);
    chk("rr_sgf",   sgf_o, 0);
    chk("rr_flags", {norm_inc_o, rnd_ovf_o, inexact_o, err_o}, 0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("rr_stay_idle", {busy_o, valid_o}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
